wired_rename: RTL and testbench

//  2-wide rename stage feeding the dispatch/ROB stage of wired_backend. Allocates in-order ROB ids to each

---
 rtl/wired_rename_pkg.sv | 16 +
 rtl/wired_rename_if.sv | 36 +++
 rtl/wired_rename_map.sv | 66 ++++++
 rtl/wired_rename.sv | 140 ++++++++++++++
 tb/tb_wired_rename.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wired_rename_pkg.sv
// Shared types and helpers for the wired_rename stage: bundle geometry and the
// architectural register id type used by the map and the interface.
package wired_rename_pkg;

  localparam int ROB_DEPTH_DEF = 32;
  localparam int NUM_SLOTS     = 2;
  localparam int NUM_SRCS      = 2;
  localparam int NUM_ARCH      = 32;

  typedef logic [4:0] arch_rid_t;

  function automatic logic [1:0] popcnt2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/wired_rename_if.sv
// Decode-bundle input, renamed-bundle output and commit port of the rename stage.
// master = upstream/dispatch/commit side, slave = the rename stage itself.
interface wired_rename_if import wired_rename_pkg::*; #(parameter int ROB_W = 5) ();

  logic                           pkg_valid_i;
  logic                           pkg_ready_o;
  logic [1:0]                     pkg_mask_i;
  arch_rid_t [1:0][1:0]           pkg_rs_i;
  arch_rid_t [1:0]                pkg_rd_i;
  logic [1:0]                     pkg_we_i;

  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [1:0]                     out_mask_o;
  logic [1:0][ROB_W-1:0]          out_rob_id_o;
  logic [1:0][1:0]                out_pend_o;
  logic [1:0][1:0][ROB_W-1:0]     out_src_rob_o;

  logic [1:0]                     c_valid_i;
  logic [1:0][ROB_W-1:0]          c_rob_id_i;
  logic [1:0]                     c_we_i;
  arch_rid_t [1:0]                c_rd_i;

  modport master (
    output pkg_valid_i, pkg_mask_i, pkg_rs_i, pkg_rd_i, pkg_we_i, out_ready_i,
           c_valid_i, c_rob_id_i, c_we_i, c_rd_i,
    input  pkg_ready_o, out_valid_o, out_mask_o, out_rob_id_o, out_pend_o, out_src_rob_o
  );

  modport slave (
    input  pkg_valid_i, pkg_mask_i, pkg_rs_i, pkg_rd_i, pkg_we_i, out_ready_i,
           c_valid_i, c_rob_id_i, c_we_i, c_rd_i,
    output pkg_ready_o, out_valid_o, out_mask_o, out_rob_id_o, out_pend_o, out_src_rob_o
  );

endinterface

// File: rtl/wired_rename_map.sv
// 32-entry arch-register -> in-flight producer map: 4 lookups that see same-cycle
// commit clears, 2 rename write ports (slot1 wins), 2 id-matched clear ports, flush.
module wired_rename_map import wired_rename_pkg::*; #(
  parameter int ROB_W = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  arch_rid_t [3:0]             look_rid,
  output logic [3:0]                  look_valid,
  output logic [3:0][ROB_W-1:0]       look_id,
  input  logic [1:0]                  wr_en,
  input  arch_rid_t [1:0]             wr_rid,
  input  logic [1:0][ROB_W-1:0]       wr_id,
  input  logic [1:0]                  clr_en,
  input  arch_rid_t [1:0]             clr_rid,
  input  logic [1:0][ROB_W-1:0]       clr_id
);

  logic [NUM_ARCH-1:0]              live;
  logic [NUM_ARCH-1:0][ROB_W-1:0]   id_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ARCH; gi++) begin : g_entry
      logic             valid_reg;
      logic [ROB_W-1:0] id_reg;
      logic             clr_hit;
      logic             wr0_hit;
      logic             wr1_hit;

      // A commit only retires the mapping if it is still the newest producer.
      assign clr_hit = valid_reg &&
                       ((clr_en[0] && clr_rid[0] == arch_rid_t'(gi) && id_reg == clr_id[0]) ||
                        (clr_en[1] && clr_rid[1] == arch_rid_t'(gi) && id_reg == clr_id[1]));
      assign wr0_hit = wr_en[0] && wr_rid[0] == arch_rid_t'(gi);
      assign wr1_hit = wr_en[1] && wr_rid[1] == arch_rid_t'(gi);

      assign live[gi]   = valid_reg && !clr_hit;
      assign id_vec[gi] = id_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          id_reg    <= '0;
        end else if (flush) begin
          valid_reg <= 1'b0;
        end else if (wr1_hit) begin
          valid_reg <= 1'b1;
          id_reg    <= wr_id[1];
        end else if (wr0_hit) begin
          valid_reg <= 1'b1;
          id_reg    <= wr_id[0];
        end else if (clr_hit) begin
          valid_reg <= 1'b0;
        end
      end
    end

    for (gi = 0; gi < 4; gi++) begin : g_look
      assign look_valid[gi] = live[look_rid[gi]];
      assign look_id[gi]    = id_vec[look_rid[gi]];
    end
  endgenerate

endmodule

// File: rtl/wired_rename.sv
// 2-wide rename stage: in-order ROB id allocation with wrap-bit pointers,
// intra-bundle bypass, producer-map lookup and a single registered output stage.
module wired_rename import wired_rename_pkg::*; #(
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  wired_rename_if.slave bus
);

  localparam int ROB_W = $clog2(ROB_DEPTH);
  typedef logic [ROB_W:0]   ptr_t;
  typedef logic [ROB_W-1:0] rid_t;

  ptr_t alloc_ptr_reg, alloc_ptr_next;
  ptr_t commit_ptr_reg, commit_ptr_next;
  ptr_t occ, free_cnt;
  logic accept;
  logic slot0_writes;

  rid_t [1:0]      slot_id;
  rid_t [1:0]      rob_id_next;
  logic [1:0][1:0] pend_next;
  rid_t [1:0][1:0] src_next;

  arch_rid_t [3:0] look_rid;
  logic [3:0]      look_valid;
  rid_t [3:0]      look_id;
  logic [1:0]      wr_en, clr_en;
  arch_rid_t [1:0] wr_rid;
  rid_t [1:0]      wr_id;

  logic            out_valid_reg;
  logic [1:0]      out_mask_reg;
  rid_t [1:0]      out_rob_id_reg;
  logic [1:0][1:0] out_pend_reg;
  rid_t [1:0][1:0] out_src_rob_reg;

  assign occ      = alloc_ptr_reg - commit_ptr_reg;
  assign free_cnt = ptr_t'(ROB_DEPTH) - occ;

  // Two free entries are always required so a full bundle can never overflow.
  assign bus.pkg_ready_o = rst_n && !flush_i && (free_cnt >= ptr_t'(2)) &&
                           (!out_valid_reg || bus.out_ready_i);
  assign accept = bus.pkg_valid_i && bus.pkg_ready_o;

  assign slot_id[0]   = alloc_ptr_reg[ROB_W-1:0];
  assign slot_id[1]   = bus.pkg_mask_i[0] ? slot_id[0] + rid_t'(1) : slot_id[0];
  assign slot0_writes = bus.pkg_mask_i[0] && bus.pkg_we_i[0] && (bus.pkg_rd_i[0] != '0);

  assign commit_ptr_next = commit_ptr_reg + ptr_t'(popcnt2(bus.c_valid_i));
  always_comb begin
    alloc_ptr_next = alloc_ptr_reg;
    if (flush_i)
      alloc_ptr_next = commit_ptr_next;
    else if (accept)
      alloc_ptr_next = alloc_ptr_reg + ptr_t'(popcnt2(bus.pkg_mask_i));
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign rob_id_next[gi] = bus.pkg_mask_i[gi] ? slot_id[gi] : '0;
      assign wr_en[gi]  = accept && bus.pkg_mask_i[gi] && bus.pkg_we_i[gi] && (bus.pkg_rd_i[gi] != '0);
      assign wr_rid[gi] = bus.pkg_rd_i[gi];
      assign wr_id[gi]  = slot_id[gi];
      assign clr_en[gi] = bus.c_valid_i[gi] && bus.c_we_i[gi] && (bus.c_rd_i[gi] != '0);
    end

    for (gi = 0; gi < NUM_SLOTS * NUM_SRCS; gi++) begin : g_src
      localparam int S = gi / 2;
      localparam int K = gi % 2;
      logic byp;
      assign look_rid[gi] = bus.pkg_rs_i[S][K];
      // Slot1 sees slot0's destination of the same bundle before the map does.
      assign byp = (S == 1) && slot0_writes && (bus.pkg_rs_i[S][K] == bus.pkg_rd_i[0]);
      assign pend_next[S][K] = bus.pkg_mask_i[S] && (bus.pkg_rs_i[S][K] != '0) &&
                               (byp || look_valid[gi]);
      assign src_next[S][K]  = !pend_next[S][K] ? '0 : (byp ? slot_id[0] : look_id[gi]);
    end
  endgenerate

  wired_rename_map #(.ROB_W(ROB_W)) u_map (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush_i),
    .look_rid   (look_rid),
    .look_valid (look_valid),
    .look_id    (look_id),
    .wr_en      (wr_en),
    .wr_rid     (wr_rid),
    .wr_id      (wr_id),
    .clr_en     (clr_en),
    .clr_rid    (bus.c_rd_i),
    .clr_id     (bus.c_rob_id_i)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_reg  <= '0;
      commit_ptr_reg <= '0;
    end else begin
      alloc_ptr_reg  <= alloc_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      out_mask_reg    <= '0;
      out_rob_id_reg  <= '0;
      out_pend_reg    <= '0;
      out_src_rob_reg <= '0;
    end else if (flush_i) begin
      out_valid_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg   <= 1'b1;
      out_mask_reg    <= bus.pkg_mask_i;
      out_rob_id_reg  <= rob_id_next;
      out_pend_reg    <= pend_next;
      out_src_rob_reg <= src_next;
    end else if (bus.out_ready_i) begin
      out_valid_reg   <= 1'b0;
    end
  end

  assign bus.out_valid_o   = out_valid_reg;
  assign bus.out_mask_o    = out_mask_reg;
  assign bus.out_rob_id_o  = out_rob_id_reg;
  assign bus.out_pend_o    = out_pend_reg;
  assign bus.out_src_rob_o = out_src_rob_reg;

  a_commit_le_occ: assert property (@(posedge clk) disable iff (!rst_n)
    ptr_t'(popcnt2(bus.c_valid_i)) <= occ);
  a_commit_in_order: assert property (@(posedge clk) disable iff (!rst_n)
    bus.c_valid_i != 2'b10);

endmodule

// File: tb/tb_wired_rename.sv
// Randomized scoreboard bench for wired_rename: a register-map/ROB-list model
// predicts each renamed bundle, a negedge monitor pops and compares.
module tb_wired_rename;
  import wired_rename_pkg::*;

  localparam int DEPTH = 32;
  localparam int RW    = 5;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  wired_rename_if #(.ROB_W(RW)) bus ();

  wired_rename #(.ROB_DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .bus     (bus)
  );

  typedef struct {
    logic [1:0]              mask;
    logic [1:0][RW-1:0]      rob;
    logic [1:0][1:0]         pend;
    logic [1:0][1:0][RW-1:0] src;
  } exp_t;

  typedef struct {
    int id;
    bit we;
    int rd;
  } rec_t;

  exp_t exp_q[$];
  rec_t infl[$];
  bit   map_v[32];
  int   map_id[32];
  int   alloc_cnt, commit_cnt;
  bit   exp_ov;
  bit   mon_en, mon_ready, mon_ov;
  int   checks   = 0;
  int   failures = 0;
  int   txn      = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic reset_model();
    for (int r = 0; r < 32; r++) begin
      map_v[r]  = 1'b0;
      map_id[r] = 0;
    end
    infl.delete();
    exp_q.delete();
    alloc_cnt  = 0;
    commit_cnt = 0;
    exp_ov     = 1'b0;
    mon_en     = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && mon_en) begin
      chk("pkg_ready", bus.pkg_ready_o, mon_ready);
      chk("out_valid", bus.out_valid_o, mon_ov);
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=bundle required=none");
        end else begin
          e = exp_q.pop_front();
          txn++;
          $display("txn %0d mask=%b ids=%0d,%0d pend=%b src=%0d,%0d,%0d,%0d", txn,
                   bus.out_mask_o, bus.out_rob_id_o[0], bus.out_rob_id_o[1], bus.out_pend_o,
                   bus.out_src_rob_o[0][0], bus.out_src_rob_o[0][1],
                   bus.out_src_rob_o[1][0], bus.out_src_rob_o[1][1]);
          chk("out_mask", bus.out_mask_o, e.mask);
          chk("out_rob_id", bus.out_rob_id_o, e.rob);
          chk("out_pend", bus.out_pend_o, e.pend);
          chk("out_src_rob", bus.out_src_rob_o, e.src);
        end
      end
    end
  end

  // Drives one cycle from posedge+1, updates the model, waits to the next posedge+1.
  task automatic step(input bit v, input logic [1:0] m, input logic [1:0][1:0][4:0] rs,
                      input logic [1:0][4:0] rd, input logic [1:0] we, input bit ordy,
                      input int ncom, input bit fl);
    int   occ, n, nxt;
    bit   rdy, acc;
    int   ids[2];
    exp_t e;
    rec_t r;
    n = (ncom > infl.size()) ? infl.size() : ncom;
    bus.c_valid_i = (n == 0) ? 2'b00 : ((n == 1) ? 2'b01 : 2'b11);
    for (int k = 0; k < 2; k++) begin
      if (k < n) begin
        bus.c_rob_id_i[k] = RW'(infl[k].id);
        bus.c_we_i[k]     = infl[k].we;
        bus.c_rd_i[k]     = 5'(infl[k].rd);
      end else begin
        bus.c_rob_id_i[k] = '0;
        bus.c_we_i[k]     = 1'b0;
        bus.c_rd_i[k]     = '0;
      end
    end
    bus.pkg_valid_i = v;
    bus.pkg_mask_i  = m;
    bus.pkg_rs_i    = rs;
    bus.pkg_rd_i    = rd;
    bus.pkg_we_i    = we;
    bus.out_ready_i = ordy;
    flush           = fl;

    occ = alloc_cnt - commit_cnt;
    rdy = !fl && (DEPTH - occ) >= 2 && (!exp_ov || ordy);
    acc = v && rdy;
    mon_ready = rdy;
    mon_ov    = exp_ov;
    mon_en    = 1'b1;

    for (int k = 0; k < n; k++) begin
      r = infl.pop_front();
      if (r.we && r.rd != 0 && map_v[r.rd] && map_id[r.rd] == r.id) map_v[r.rd] = 1'b0;
      commit_cnt++;
    end

    if (acc) begin
      nxt    = alloc_cnt;
      e.mask = m;
      for (int s = 0; s < 2; s++) begin
        if (m[s]) begin
          ids[s] = nxt % DEPTH;
          nxt++;
        end else begin
          ids[s] = 0;
        end
        e.rob[s] = RW'(ids[s]);
      end
      for (int s = 0; s < 2; s++) begin
        for (int k = 0; k < 2; k++) begin
          e.pend[s][k] = 1'b0;
          e.src[s][k]  = '0;
          if (m[s] && rs[s][k] != 0) begin
            if (s == 1 && m[0] && we[0] && rd[0] != 0 && rs[1][k] == rd[0]) begin
              e.pend[s][k] = 1'b1;
              e.src[s][k]  = RW'(ids[0]);
            end else if (map_v[rs[s][k]]) begin
              e.pend[s][k] = 1'b1;
              e.src[s][k]  = RW'(map_id[rs[s][k]]);
            end
          end
        end
      end
      for (int s = 0; s < 2; s++) begin
        if (m[s]) begin
          if (we[s] && rd[s] != 0) begin
            map_v[rd[s]]  = 1'b1;
            map_id[rd[s]] = ids[s];
          end
          r.id = ids[s];
          r.we = we[s];
          r.rd = int'(rd[s]);
          infl.push_back(r);
        end
      end
      alloc_cnt = nxt;
      exp_q.push_back(e);
    end

    if (fl) begin
      for (int q = 0; q < 32; q++) map_v[q] = 1'b0;
      infl.delete();
      alloc_cnt = commit_cnt;
      if (exp_ov && !ordy) exp_q.delete(0);
      exp_ov = 1'b0;
    end else begin
      exp_ov = acc ? 1'b1 : (ordy ? 1'b0 : exp_ov);
    end

    @(posedge clk);
    #1;
  endtask

  task automatic rand_step(input int commit_pct, input int flush_pct);
    logic [1:0][1:0][4:0] rs;
    logic [1:0][4:0]      rd;
    int nc;
    for (int s = 0; s < 2; s++) begin
      rd[s] = 5'($urandom_range(0, 7));
      for (int k = 0; k < 2; k++) rs[s][k] = 5'($urandom_range(0, 7));
    end
    nc = ($urandom_range(0, 99) < commit_pct) ? $urandom_range(1, 2) : 0;
    step($urandom_range(0, 99) < 80, 2'($urandom_range(0, 3)), rs, rd, 2'($urandom_range(0, 3)),
         $urandom_range(0, 99) < 75, nc, $urandom_range(0, 99) < flush_pct);
  endtask

  initial begin
    bus.pkg_valid_i = 1'b0;
    bus.pkg_mask_i  = '0;
    bus.pkg_rs_i    = '0;
    bus.pkg_rd_i    = '0;
    bus.pkg_we_i    = '0;
    bus.out_ready_i = 1'b0;
    bus.c_valid_i   = '0;
    bus.c_rob_id_i  = '0;
    bus.c_we_i      = '0;
    bus.c_rd_i      = '0;
    reset_model();

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_ready", bus.pkg_ready_o, 0);
    chk("rst_out_mask", bus.out_mask_o, 0);
    chk("rst_out_rob_id", bus.out_rob_id_o, 0);
    chk("rst_out_pend", bus.out_pend_o, 0);
    chk("rst_out_src", bus.out_src_rob_o, 0);
    rst_n = 1'b1;

    // First bundle: rd={5,3}, all sources r0.
    step(1, 2'b11, '0, {5'd5, 5'd3}, 2'b11, 1, 0, 0);
    chk("first_ids", bus.out_rob_id_o, {5'd1, 5'd0});
    chk("first_pend", bus.out_pend_o, 0);
    chk("first_alloc", dut.alloc_ptr_reg, 2);
    // Slot1 reads slot0's rd=4 in the same bundle (id2).
    step(1, 2'b11, {5'd0, 5'd4, 5'd0, 5'd0}, {5'd10, 5'd4}, 2'b11, 1, 0, 0);
    chk("bypass_pend", bus.out_pend_o[1][0], 1);
    chk("bypass_src", bus.out_src_rob_o[1][0], 2);
    step(1, 2'b11, {5'd0, 5'd7, 5'd0, 5'd0}, {5'd11, 5'd7}, 2'b11, 1, 0, 0);
    // id6 becomes the newer producer of r4; committing id2 must keep it.
    step(1, 2'b01, '0, {5'd0, 5'd4}, 2'b01, 1, 0, 0);
    step(0, 2'b00, '0, '0, 2'b00, 1, 2, 0);
    step(0, 2'b00, '0, '0, 2'b00, 1, 1, 0);
    step(1, 2'b01, {5'd0, 5'd0, 5'd0, 5'd4}, {5'd0, 5'd0}, 2'b00, 1, 0, 0);
    chk("newer_pend", bus.out_pend_o[0][0], 1);
    chk("newer_src", bus.out_src_rob_o[0][0], 6);

    // Fill toward full without commits, then free two entries.
    step(1, 2'b01, '0, {5'd0, 5'd12}, 2'b01, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 2'b11, '0, {5'd14, 5'd13}, 2'b11, 1, 0, 0);
    step(1, 2'b11, '0, '0, 2'b00, 1, 2, 0);
    step(1, 2'b11, '0, '0, 2'b00, 1, 0, 0);

    for (int i = 0; i < 600; i++) rand_step(55, 3);

    // Flush with a same-cycle commit, then every source must be ready in the ARF.
    step(1, 2'b11, '0, {5'd2, 5'd1}, 2'b11, 0, 0, 0);
    step(0, 2'b00, '0, '0, 2'b00, 0, 1, 1);
    step(1, 2'b11, {5'd4, 5'd3, 5'd2, 5'd1}, {5'd6, 5'd5}, 2'b11, 1, 0, 0);
    chk("post_flush_pend", bus.out_pend_o, 0);

    for (int i = 0; i < 100; i++) rand_step(50, 2);

    // Reset in the middle of traffic.
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", bus.out_valid_o, 0);
    chk("midrst_ready", bus.pkg_ready_o, 0);
    chk("midrst_out_mask", bus.out_mask_o, 0);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 200; i++) rand_step(60, 2);
    for (int i = 0; i < 3; i++) step(0, 2'b00, '0, '0, 2'b00, 1, 0, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
